// File: rtl/gnrc_stream_pkg.sv
// Shared constants and helpers for the FIFO-to-stream adapter.
// Buffer geometry and circular pointer increment.
package gnrc_stream_pkg;

    localparam int unsigned BUF_DEPTH = 3;
    localparam int unsigned PTR_W     = 2;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/gnrc_fifo2stream.sv
// Read-side adapter: pulls words from a standard or FWFT FIFO and
// presents them as a fully registered valid/ready stream.
module gnrc_fifo2stream
    import gnrc_stream_pkg::*;
#(
    parameter int DW   = 32,
    parameter bit FWFT = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          fifo_empty_i,
    input  logic [DW-1:0] fifo_data_i,
    output logic          fifo_ren_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o,
    output logic [1:0]    cnt_o
);

    logic [DW-1:0]    mem_q [BUF_DEPTH];
    logic [DW-1:0]    mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             infl_q;
    logic             valid_q;
    logic [DW-1:0]    data_q;
    logic [2:0]       credit;
    logic             ren;
    logic             wr;
    logic             pop;

    // Credit counts in-flight reads so the buffer can never overflow
    // regardless of what the sink does this cycle.
    assign credit = {1'b0, occ_q} + {2'b00, infl_q};
    assign ren    = rst_ni & ~flush_i & ~fifo_empty_i
                  & (credit < 3'(BUF_DEPTH));
    assign wr     = ~flush_i & (FWFT ? ren : infl_q);
    assign pop    = valid_q & m_ready_i;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q + {1'b0, wr} - {1'b0, pop};
        if (wr) begin
            mem_d[wptr_q] = fifo_data_i;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rptr_q  <= '0;
            wptr_q  <= '0;
            occ_q   <= '0;
            infl_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            occ_q   <= occ_d;
            infl_q  <= FWFT ? 1'b0 : ren;
            valid_q <= (occ_d != 2'd0);
            data_q  <= mem_d[rptr_d];
        end
    end

    assign fifo_ren_o = ren;
    assign m_valid_o  = valid_q;
    assign m_data_o   = data_q;
    assign cnt_o      = occ_q + {1'b0, infl_q};

endmodule

// File: tb/tb_gnrc_fifo2stream.sv
// Bench for gnrc_fifo2stream: standard and FWFT instances side by side,
// FIFO models, scoreboard monitor, directed and random phases.
module tb_gnrc_fifo2stream;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               ready = 1'b0;
    logic [1:0]         empty = 2'b11;
    logic [1:0]         ren;
    logic [1:0]         valid;
    logic [1:0][DW-1:0] fdata = '0;
    logic [1:0][DW-1:0] mdata;
    logic [1:0][1:0]    cnt;

    gnrc_fifo2stream #(.DW(DW), .FWFT(1'b0)) u_std (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .fifo_empty_i(empty[0]), .fifo_data_i(fdata[0]),
        .fifo_ren_o(ren[0]), .m_valid_o(valid[0]),
        .m_ready_i(ready), .m_data_o(mdata[0]), .cnt_o(cnt[0])
    );

    gnrc_fifo2stream #(.DW(DW), .FWFT(1'b1)) u_fwft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .fifo_empty_i(empty[1]), .fifo_data_i(fdata[1]),
        .fifo_ren_o(ren[1]), .m_valid_o(valid[1]),
        .m_ready_i(ready), .m_data_o(mdata[1]), .cnt_o(cnt[1])
    );

    logic [DW-1:0] src [$];
    int            n_pub = 0;
    int            rd [2] = '{0, 0};
    logic [1:0]    ren_q = 2'b00;
    logic [DW-1:0] expq [2][$];
    int            got [2] = '{0, 0};
    logic [1:0]    hold = 2'b00;
    logic [DW-1:0] hold_d [2];
    int            total = 0;
    int            bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endfunction

    // Upstream FIFO models: words src[rd..n_pub-1] are held in the FIFO.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (ren_q[m]) rd[m] = rd[m] + 1;
            empty[m] <= (rd[m] >= n_pub);
            if (m == 1) begin
                fdata[m] <= (rd[m] < n_pub) ? src[rd[m]] : '0;
            end else if (ren_q[m]) begin
                fdata[m] <= src[rd[m] - 1];
            end
        end
    end

    // Scoreboard: every FIFO pop is expected on the stream, in order,
    // unless a flush or reset discards it.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst_n) begin
                chk($sformatf("cnt%0d", m), 32'(cnt[m]),
                    32'(expq[m].size()));
            end
            if (!rst_n || flush) begin
                chk($sformatf("ren_idle%0d", m), 32'(ren[m]), 32'd0);
                expq[m].delete();
                hold[m] = 1'b0;
            end else begin
                if (hold[m]) begin
                    chk($sformatf("hold_v%0d", m), 32'(valid[m]), 32'd1);
                    chk($sformatf("hold_d%0d", m), mdata[m], hold_d[m]);
                end
                if (valid[m] && ready) begin
                    if (expq[m].size() == 0) begin
                        chk($sformatf("extra%0d", m), mdata[m], 32'hDEAD_BEEF);
                    end else begin
                        chk($sformatf("data%0d", m), mdata[m],
                            expq[m].pop_front());
                    end
                    got[m]++;
                end
                if (ren[m]) expq[m].push_back(src[rd[m]]);
                hold[m]   = valid[m] & ~ready;
                hold_d[m] = mdata[m];
            end
            ren_q[m] = ren[m];
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] w);
        src.push_back(w);
        n_pub++;
    endtask

    task automatic drain(input int lim);
        bit done;
        done  = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < lim && !done; i++) begin
            nxt();
            obs();
            done = (expq[0].size() == 0) && (expq[1].size() == 0)
                && (rd[0] == n_pub) && (rd[1] == n_pub) && (valid == 2'b00);
        end
        chk("drain", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses [2];
        int base [2];
        int sent;
        bit seen;

        nxt();
        nxt();
        obs();
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid", 32'(valid[m]), 32'd0);
            chk("rst_data", mdata[m], 32'd0);
            chk("rst_cnt", 32'(cnt[m]), 32'd0);
            chk("rst_ren", 32'(ren[m]), 32'd0);
        end
        nxt();
        rst_n = 1'b1;

        // single word latency
        nxt();
        push(32'hA5);
        ready = 1'b1;
        nxt();
        obs();
        chk("t1_ren_std", 32'(ren[0]), 32'd1);
        chk("t1_ren_fwft", 32'(ren[1]), 32'd1);
        nxt();
        obs();
        chk("t1_ren_std_off", 32'(ren[0]), 32'd0);
        chk("t1_cnt_t1", 32'(cnt[0]), 32'd1);
        chk("t1_v_std_t1", 32'(valid[0]), 32'd0);
        chk("t1_v_fwft_t1", 32'(valid[1]), 32'd1);
        chk("t1_d_fwft", mdata[1], 32'hA5);
        nxt();
        obs();
        chk("t1_v_std_t2", 32'(valid[0]), 32'd1);
        chk("t1_d_std", mdata[0], 32'hA5);
        chk("t1_cnt_t2", 32'(cnt[0]), 32'd1);
        chk("t1_v_fwft_t2", 32'(valid[1]), 32'd0);
        nxt();
        obs();
        chk("t1_v_std_t3", 32'(valid[0]), 32'd0);
        chk("t1_cnt_t3", 32'(cnt[0]), 32'd0);
        drain(20);

        // FWFT back-to-back 1..8
        nxt();
        push(32'd1);
        for (int c = 0; c < 10; c++) begin
            nxt();
            if (c + 2 <= 8) push(32'(c + 2));
            obs();
            if (c >= 1 && c <= 8) begin
                chk("t2_valid", 32'(valid[1]), 32'd1);
                chk("t2_data", mdata[1], 32'(c));
            end else begin
                chk("t2_idle", 32'(valid[1]), 32'd0);
            end
        end
        drain(30);

        // backpressure: 10 words, stall 20 cycles
        nxt();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
        pulses = '{0, 0};
        for (int c = 0; c < 20; c++) begin
            nxt();
            obs();
            for (int m = 0; m < 2; m++) begin
                if (ren[m]) pulses[m]++;
                if (valid[m]) chk("t3_head", mdata[m], 32'h100);
            end
        end
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("t3_pulses%0d", m), 32'(pulses[m]), 32'd3);
            chk($sformatf("t3_full%0d", m), 32'(valid[m]), 32'd1);
        end
        nxt();
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            obs();
            for (int m = 0; m < 2; m++) begin
                chk("t3_run_v", 32'(valid[m]), 32'd1);
                chk("t3_run_d", mdata[m], 32'h100 + 32'(k));
            end
            nxt();
        end
        drain(30);

        // flush right after a read, two words buffered
        nxt();
        ready = 1'b0;
        push(32'h200);
        push(32'h201);
        repeat (5) nxt();
        push(32'h202);
        nxt();
        obs();
        chk("t5_ren", 32'(ren[0]), 32'd1);
        chk("t5_cnt_pre", 32'(cnt[0]), 32'd2);
        nxt();
        flush = 1'b1;
        obs();
        chk("t5_ren_flush", 32'(ren[0]), 32'd0);
        chk("t5_cnt_flush", 32'(cnt[0]), 32'd3);
        nxt();
        flush = 1'b0;
        obs();
        for (int m = 0; m < 2; m++) begin
            chk("t5_valid_post", 32'(valid[m]), 32'd0);
            chk("t5_cnt_post", 32'(cnt[m]), 32'd0);
        end
        nxt();
        push(32'h203);
        ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            nxt();
            obs();
            seen = valid[0];
        end
        chk("t5_resume_v", 32'(valid[0]), 32'd1);
        chk("t5_resume_d", mdata[0], 32'h203);
        drain(30);

        // reset mid-stream with 3 words buffered
        nxt();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
        repeat (8) nxt();
        obs();
        for (int m = 0; m < 2; m++) begin
            chk("t6_full", 32'(cnt[m]), 32'd3);
        end
        nxt();
        rst_n = 1'b0;
        obs();
        nxt();
        rst_n = 1'b1;
        obs();
        for (int m = 0; m < 2; m++) begin
            chk("t6_valid", 32'(valid[m]), 32'd0);
            chk("t6_data", mdata[m], 32'd0);
            chk("t6_cnt", 32'(cnt[m]), 32'd0);
        end
        drain(40);

        // random traffic
        base = got;
        sent = 0;
        while (sent < 1000) begin
            nxt();
            ready = 1'($urandom % 2);
            if ($urandom % 5 < 2) begin
                push($urandom);
                sent++;
            end
        end
        drain(300);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rand_count%0d", m), 32'(got[m] - base[m]), 32'd1000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
